// File: rtl/axi_cache_arbiter_pkg.sv
// Shared definitions for the cache-to-AXI arbiter: AXI ids, FSM encodings, burst helpers.
package axi_cache_arbiter_pkg;

    localparam int unsigned LINE_WORDS = 4;
    localparam logic [3:0] AXI_ID_INST = 4'd0;
    localparam logic [3:0] AXI_ID_DATA = 4'd1;
    localparam logic [2:0] AXI_SIZE_WORD = 3'd2;

    typedef enum logic [1:0] {
        RIdle,
        RAr,
        RData
    } rd_state_e;

    typedef enum logic [1:0] {
        WIdle,
        WAw,
        WData,
        WResp
    } wr_state_e;

    function automatic logic [7:0] burst_len(input logic line, input int unsigned words);
        return line ? 8'(words - 1) : 8'd0;
    endfunction

endpackage

// File: rtl/axi_cache_arbiter_wr_buffer.sv
// Write-side line buffer: holds one accepted write and serves W beats from it.
module axi_wr_buffer
    import axi_cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     load,
    input  logic [ADDR_W-1:0]        load_addr,
    input  logic                     load_type,
    input  logic [3:0]               load_wstrb,
    input  logic [32*LINE_WORDS-1:0] load_data,
    input  logic                     beat,
    output logic [ADDR_W-1:0]        addr,
    output logic [7:0]               len,
    output logic [3:0]               wstrb,
    output logic [31:0]              wdata,
    output logic                     wlast
);

    localparam int unsigned CntW = (LINE_WORDS > 1) ? $clog2(LINE_WORDS) : 1;

    logic [ADDR_W-1:0]        addr_q;
    logic [7:0]               len_q;
    logic [3:0]               wstrb_q;
    logic [32*LINE_WORDS-1:0] data_q;
    logic [CntW-1:0]          cnt_q;
    logic [31:0]              words [LINE_WORDS];

    always_ff @(posedge clk) begin
        if (reset) begin
            addr_q  <= '0;
            len_q   <= '0;
            wstrb_q <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
        end else if (load) begin
            addr_q  <= load_addr;
            len_q   <= burst_len(load_type, LINE_WORDS);
            wstrb_q <= load_type ? 4'hf : load_wstrb;
            data_q  <= load_data;
            cnt_q   <= '0;
        end else if (beat) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    for (genvar i = 0; i < LINE_WORDS; i++) begin : g_words
        assign words[i] = data_q[32*i +: 32];
    end

    assign addr  = addr_q;
    assign len   = len_q;
    assign wstrb = wstrb_q;
    assign wdata = words[cnt_q];
    assign wlast = (8'(cnt_q) == len_q);

endmodule

// File: rtl/axi_cache_arbiter.sv
// Shares one AXI master between icache reads, dcache reads and the dcache write path,
// with concurrent read/write FSMs and a same-line read-after-write stall.
module axi_cache_arbiter
    import axi_cache_arbiter_pkg::*;
#(
    parameter int unsigned LINE_WORDS = 4,
    parameter int unsigned ADDR_W     = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_rd_req,
    output logic                     i_rd_rdy,
    input  logic                     i_rd_type,
    input  logic [ADDR_W-1:0]        i_rd_addr,
    input  logic                     d_rd_req,
    output logic                     d_rd_rdy,
    input  logic                     d_rd_type,
    input  logic [ADDR_W-1:0]        d_rd_addr,
    output logic                     i_ret_valid,
    output logic                     d_ret_valid,
    output logic                     ret_last,
    output logic [31:0]              ret_data,
    input  logic                     wr_req,
    output logic                     wr_rdy,
    input  logic                     wr_type,
    input  logic [ADDR_W-1:0]        wr_addr,
    input  logic [3:0]               wr_wstrb,
    input  logic [32*LINE_WORDS-1:0] wr_data,
    output logic [3:0]               arid,
    output logic [ADDR_W-1:0]        araddr,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic                     arvalid,
    input  logic                     arready,
    input  logic [3:0]               rid,
    input  logic [31:0]              rdata,
    input  logic                     rlast,
    input  logic                     rvalid,
    output logic                     rready,
    output logic [ADDR_W-1:0]        awaddr,
    output logic [7:0]               awlen,
    output logic [2:0]               awsize,
    output logic                     awvalid,
    input  logic                     awready,
    output logic [31:0]              wdata,
    output logic [3:0]               wstrb,
    output logic                     wlast,
    output logic                     wvalid,
    input  logic                     wready,
    input  logic                     bvalid,
    output logic                     bready
);

    rd_state_e         rd_state_q, rd_state_d;
    wr_state_e         wr_state_q, wr_state_d;
    logic              rd_data_q;
    logic [ADDR_W-1:0] araddr_q;
    logic [7:0]        arlen_q;

    logic              wr_busy, wr_take, hazard_on;
    logic              d_block, i_block, d_take, i_take;
    logic [ADDR_W-5:0] wr_line;
    logic [ADDR_W-1:0] buf_addr;
    logic              unused_rid;

    assign unused_rid = ^rid;

    // A write accepted this very cycle already guards its line against reads.
    assign wr_busy   = (wr_state_q != WIdle);
    assign wr_take   = !reset && (wr_state_q == WIdle) && wr_req;
    assign hazard_on = wr_busy || wr_take;
    assign wr_line   = wr_busy ? buf_addr[ADDR_W-1:4] : wr_addr[ADDR_W-1:4];
    assign d_block   = hazard_on && (d_rd_addr[ADDR_W-1:4] == wr_line);
    assign i_block   = hazard_on && (i_rd_addr[ADDR_W-1:4] == wr_line);

    assign d_take = !reset && (rd_state_q == RIdle) && d_rd_req && !d_block;
    assign i_take = !reset && (rd_state_q == RIdle) && i_rd_req && !i_block && !d_take;

    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            RIdle:   if (d_take || i_take) rd_state_d = RAr;
            RAr:     if (arready) rd_state_d = RData;
            RData:   if (rvalid && rlast) rd_state_d = RIdle;
            default: rd_state_d = RIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_state_q <= RIdle;
            rd_data_q  <= 1'b0;
            araddr_q   <= '0;
            arlen_q    <= '0;
        end else begin
            rd_state_q <= rd_state_d;
            if (d_take) begin
                rd_data_q <= 1'b1;
                araddr_q  <= d_rd_addr;
                arlen_q   <= burst_len(d_rd_type, LINE_WORDS);
            end else if (i_take) begin
                rd_data_q <= 1'b0;
                araddr_q  <= i_rd_addr;
                arlen_q   <= burst_len(i_rd_type, LINE_WORDS);
            end
        end
    end

    assign d_rd_rdy    = d_take;
    assign i_rd_rdy    = i_take;
    assign arid        = rd_data_q ? AXI_ID_DATA : AXI_ID_INST;
    assign araddr      = araddr_q;
    assign arlen       = arlen_q;
    assign arsize      = AXI_SIZE_WORD;
    assign arvalid     = !reset && (rd_state_q == RAr);
    assign rready      = !reset && (rd_state_q == RData);
    assign i_ret_valid = rready && rvalid && !rd_data_q;
    assign d_ret_valid = rready && rvalid && rd_data_q;
    assign ret_data    = rdata;
    assign ret_last    = rlast;

    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            WIdle:   if (wr_take) wr_state_d = WAw;
            WAw:     if (awready) wr_state_d = WData;
            WData:   if (wready && wlast) wr_state_d = WResp;
            WResp:   if (bvalid) wr_state_d = WIdle;
            default: wr_state_d = WIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_state_q <= WIdle;
        end else begin
            wr_state_q <= wr_state_d;
        end
    end

    assign wr_rdy  = wr_take;
    assign awvalid = !reset && (wr_state_q == WAw);
    assign wvalid  = !reset && (wr_state_q == WData);
    assign bready  = !reset && (wr_state_q == WResp);
    assign awaddr  = buf_addr;
    assign awsize  = AXI_SIZE_WORD;

    axi_wr_buffer #(
        .LINE_WORDS (LINE_WORDS),
        .ADDR_W     (ADDR_W)
    ) u_wr_buffer (
        .clk        (clk),
        .reset      (reset),
        .load       (wr_take),
        .load_addr  (wr_addr),
        .load_type  (wr_type),
        .load_wstrb (wr_wstrb),
        .load_data  (wr_data),
        .beat       (wvalid && wready),
        .addr       (buf_addr),
        .len        (awlen),
        .wstrb      (wstrb),
        .wdata      (wdata),
        .wlast      (wlast)
    );

endmodule

// File: doc/axi_cache_arbiter.md
Name: axi_cache_arbiter

Overview:
Shares the single AXI master port of the core between the instruction cache (refill and uncached fetch reads), the data cache (refill and uncached loads), and the data-cache write path (dirty-line writeback and uncached stores). It sits between the two caches and the SoC AXI interconnect. It runs one read FSM and one write FSM that operate concurrently, with a read-after-write address hazard check between them. Fixed AXI fields (burst=INCR, lock, cache, prot, wid=awid=1) are tied off in the top level, not here.

Parameters:
LINE_WORDS, 4, words per cache line; sets line-burst arlen/awlen = LINE_WORDS-1
ADDR_W, 32, physical address width

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_rd_req / i_rd_rdy  in/out  1/1  icache read request and accept handshake
i_rd_type  in  1  0 = single word (uncached), 1 = line
i_rd_addr  in  32  icache read address
d_rd_req / d_rd_rdy  in/out  1/1  dcache read request and accept handshake
d_rd_type  in  1  0 = word, 1 = line
d_rd_addr  in  32  dcache read address
i_ret_valid / d_ret_valid  out  1/1  per-requester return-beat strobes
ret_last  out  1  last beat of the current read
ret_data  out  32  return data, shared by both requesters
wr_req / wr_rdy  in/out  1/1  write request and accept handshake
wr_type  in  1  0 = word, 1 = line
wr_addr  in  32  write address
wr_wstrb  in  4  byte strobe (word writes only)
wr_data  in  32*LINE_WORDS  write data; word writes use [31:0]
arid/araddr/arlen/arsize  out  4/32/8/3  AR channel
arvalid/arready  out/in  1/1  AR handshake
rid/rdata/rlast  in  4/32/1  R channel
rvalid/rready  in/out  1/1  R handshake
awaddr/awlen/awsize  out  32/8/3  AW channel
awvalid/awready  out/in  1/1  AW handshake
wdata/wstrb/wlast  out  32/4/1  W channel
wvalid/wready  out/in  1/1  W handshake
bvalid/bready  in/out  1/1  B handshake

Behaviour:
- Reset: both FSMs go to IDLE. All valid, ready and rdy outputs are 0. araddr, awaddr, wdata, beat counter and latched buffers are cleared. Reset mid-burst abandons the transaction; the AXI slave is reset in the same cycle.
- Read FSM states: R_IDLE -> R_AR -> R_DATA -> R_IDLE.
- R_IDLE arbitration: a data read beats an instruction read (fixed priority). The winner must not be hazard-blocked.
- Accept: rdy=1 for exactly the accept cycle, combinationally in R_IDLE. The request is latched, arvalid=1 from the next cycle.
- Latched request: arid=0 for icache, 1 for dcache. arlen = type ? LINE_WORDS-1 : 0. arsize=2.
- R_AR: hold arvalid and the address stable until arready. Then move to R_DATA.
- R_DATA: rready=1. Each rvalid beat drives ret_data=rdata and ret_last=rlast, and asserts i_ret_valid or d_ret_valid as selected by the latched id, in the same cycle (zero added latency). On rlast, return to R_IDLE. A new accept is allowed the following cycle.
- Write FSM states: W_IDLE -> W_AW -> W_DATA -> W_RESP -> W_IDLE.
- W_IDLE: when wr_req, assert wr_rdy for one cycle and latch addr, type, strobe and data into a line buffer. The cache may reuse its buffer immediately after accept.
- W_AW: awvalid until awready. awlen as for reads. wstrb = wr_wstrb for word writes, 4'hf for line writes.
- W_DATA: wvalid=1. A beat counter (log2 LINE_WORDS bits) selects wdata = buffer word[cnt] and advances on each wready. wlast=1 when cnt == awlen. AW and W are not overlapped.
- W_RESP: bready=1. On bvalid, return to W_IDLE. bresp is ignored.
- RAW hazard: while the write FSM is not in W_IDLE, a read whose addr[31:4] equals the latched write addr[31:4] is not accepted. This applies to both requesters.
- Hazard stall is not starvation: the blocked read waits, and a non-blocked icache read may proceed meanwhile.
- Same-cycle wr_req and a same-line d_rd_req: the write is accepted first and the read stalls until W_IDLE.
- Read and write to different lines proceed fully in parallel.
- rid is not checked (single outstanding read). An rvalid outside R_DATA is ignored; the bench asserts this never happens.

Decomposition:
- Shared header (mycpu.h) defines: AXI_ID_INST=0, AXI_ID_DATA=1, the state encodings for both FSMs, and LINE_WORDS.
- One natural sub-module: axi_wr_buffer (line buffer, beat counter, wdata/wlast mux). Read path stays inline.

Test Plan:
- icache line read at 0x1fc00000 -> araddr=0x1fc00000, arlen=3, arid=0; 4 i_ret_valid beats, ret_last on beat 4; d_ret_valid never asserted.
- Same-cycle i_rd_req (0x1000) and d_rd_req (0x2000) -> d_rd_rdy first, arid=1 for 0x2000; i_rd_rdy only after d's rlast; icache AR issued for 0x1000.
- Dirty writeback to 0x3000 with data words A,B,C,D, plus d_rd_req at 0x3008 -> read held until bvalid handshake; AW len=3, W beats A,B,C,D, wlast on D; then the read is issued.
- Uncached store 0xbeef at 0x1faf0000 with wstrb=4'b0011 -> awlen=0, single W beat with wstrb=4'b0011, wlast=1.
- Write to 0x4000 and icache read of 0x5000 together -> AR and AW in flight simultaneously; both complete.
- Reset asserted mid R_DATA beat 2 -> next cycle arvalid=rready=awvalid=wvalid=0 and both rdy=0; a fresh read afterwards completes normally.
